// File: rtl/serial_nibble_adder.sv
// Wide unsigned adder that streams WIDTH-bit operands through one 4-bit add slice, LSB nibble first.
// Optional macro SERIAL_ADDER_OVERFLOW_EN adds a registered two's-complement overflow_out port.
module serial_nibble_adder #(
    parameter int WIDTH   = 16,
    parameter int NIBBLES = WIDTH / 4
) (
    input  logic             clk_in,
    input  logic             reset_n_in,
    input  logic             start_in,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             carry_in,
    output logic             ready_out,
    output logic             done_out,
    output logic [WIDTH-1:0] sum_out,
    output logic             carry_out
`ifdef SERIAL_ADDER_OVERFLOW_EN
    ,
    output logic             overflow_out
`endif
);

    localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [CW-1:0] LAST_NIB = CW'(NIBBLES - 1);
    // Result shift register holds only the nibbles finished before the last one.
    localparam int RW = (NIBBLES > 1) ? WIDTH - 4 : 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic logic [4:0] add_nibble(
        input logic [3:0] a,
        input logic [3:0] b,
        input logic       cin
    );
        logic [3:0] lo;
        logic [1:0] hi;
        lo = {1'b0, a[2:0]} + {1'b0, b[2:0]} + {3'b000, cin};
        hi = {1'b0, a[3]} + {1'b0, b[3]} + {1'b0, lo[3]};
        return {hi, lo[2:0]};
    endfunction

`ifdef SERIAL_ADDER_OVERFLOW_EN
    function automatic logic msb_carry_in(
        input logic [3:0] a,
        input logic [3:0] b,
        input logic       cin
    );
        logic [3:0] lo;
        lo = {1'b0, a[2:0]} + {1'b0, b[2:0]} + {3'b000, cin};
        return lo[3];
    endfunction
`endif

    state_t             r_state;
    state_t             w_next;
    logic               r_ready;
    logic               r_done;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic               r_carry;
    logic [CW-1:0]      r_cnt;
    logic [RW-1:0]      r_res;
    logic [WIDTH-1:0]   r_sum;
    logic               r_cout;
    logic [3:0]         w_sum;
    logic               w_cout;
    logic               w_last;
    logic [RW-1:0]      w_res_shift;
    logic [WIDTH-1:0]   w_result;

    assign {w_cout, w_sum} = add_nibble(r_a[3:0], r_b[3:0], r_carry);
    assign w_last          = (r_cnt == LAST_NIB);

    generate
        if (NIBBLES > 2) begin : g_multi
            assign w_res_shift = {w_sum, r_res[RW-1:4]};
            assign w_result    = {w_sum, r_res};
        end else if (NIBBLES == 2) begin : g_two
            assign w_res_shift = w_sum;
            assign w_result    = {w_sum, r_res};
        end else begin : g_one
            assign w_res_shift = w_sum;
            assign w_result    = w_sum;
        end
    endgenerate

    // State register plus ready/done flags registered from the next state.
    always_ff @(posedge clk_in) begin
        if (!reset_n_in) begin
            r_state <= ST_IDLE;
            r_ready <= 1'b1;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_ready <= (w_next == ST_IDLE);
            r_done  <= (w_next == ST_DONE);
        end
    end

    // Next-state decode.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start_in) begin
                    w_next = ST_RUN;
                end else begin
                    w_next = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (w_last) begin
                    w_next = ST_DONE;
                end else begin
                    w_next = ST_RUN;
                end
            end
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // Operand capture, per-nibble datapath and result registers.
    always_ff @(posedge clk_in) begin
        if (!reset_n_in) begin
            r_a     <= {WIDTH{1'b0}};
            r_b     <= {WIDTH{1'b0}};
            r_carry <= 1'b0;
            r_cnt   <= {CW{1'b0}};
            r_res   <= {RW{1'b0}};
            r_sum   <= {WIDTH{1'b0}};
            r_cout  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start_in) begin
                        r_a     <= a_in;
                        r_b     <= b_in;
                        r_carry <= carry_in;
                        r_cnt   <= {CW{1'b0}};
                    end
                end
                ST_RUN: begin
                    r_a     <= r_a >> 3'd4;
                    r_b     <= r_b >> 3'd4;
                    r_carry <= w_cout;
                    r_cnt   <= r_cnt + 1'b1;
                    r_res   <= w_res_shift;
                    if (w_last) begin
                        r_sum  <= w_result;
                        r_cout <= w_cout;
                    end
                end
                ST_DONE: begin
                    r_cnt <= {CW{1'b0}};
                end
                default: begin
                    r_cnt <= {CW{1'b0}};
                end
            endcase
        end
    end

`ifdef SERIAL_ADDER_OVERFLOW_EN
    logic r_ovf;

    // Overflow is the carry into the MSB bit XOR the carry out of it, taken on the final nibble.
    always_ff @(posedge clk_in) begin
        if (!reset_n_in) begin
            r_ovf <= 1'b0;
        end else if ((r_state == ST_RUN) && w_last) begin
            r_ovf <= msb_carry_in(r_a[3:0], r_b[3:0], r_carry) ^ w_cout;
        end
    end

    assign overflow_out = r_ovf;
`endif

    assign ready_out = r_ready;
    assign done_out  = r_done;
    assign sum_out   = r_sum;
    assign carry_out = r_cout;

endmodule

// File: tb/tb_serial_nibble_adder.sv
// Scoreboard bench for serial_nibble_adder at WIDTH=16; define SERIAL_ADDER_OVERFLOW_EN to also check overflow_out.
module tb_serial_nibble_adder;

    localparam int W = 16;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } exp_t;

    logic         clk;
    logic         reset_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         ready_out;
    logic         done_out;
    logic [W-1:0] sum_out;
    logic         carry_out;
`ifdef SERIAL_ADDER_OVERFLOW_EN
    logic         overflow_out;
`endif

    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_done  = 0;
    int   n_acc   = 0;
    int   cyc     = 0;
    int   last_acc_cyc = 0;
    int   prev_acc_cyc = 0;

    serial_nibble_adder #(.WIDTH(W)) dut (
        .clk_in     (clk),
        .reset_n_in (reset_n),
        .start_in   (start),
        .a_in       (a),
        .b_in       (b),
        .carry_in   (cin),
        .ready_out  (ready_out),
        .done_out   (done_out),
        .sum_out    (sum_out),
        .carry_out  (carry_out)
`ifdef SERIAL_ADDER_OVERFLOW_EN
        ,
        .overflow_out (overflow_out)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        exp_t       e;
        logic [W:0] full;
        full   = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
        e.sum  = full[W-1:0];
        e.cout = full[W];
        e.ovf  = (x[W-1] == y[W-1]) && (full[W-1] != x[W-1]);
        return e;
    endfunction

    // One clock: predict acceptance before the edge, then score any done pulse after it.
    task automatic step();
        logic in_reset;
        in_reset = !reset_n;
        if (reset_n && start && ready_out === 1'b1) begin
            sb_q.push_back(model(a, b, cin));
            n_acc++;
            prev_acc_cyc = last_acc_cyc;
            last_acc_cyc = cyc;
        end
        @(posedge clk);
        #1;
        cyc++;
        if (in_reset) sb_q.delete();
        if (done_out === 1'b1) begin
            n_done++;
            if (sb_q.size() == 0) begin
                check_val("spurious_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check_val("sum", 32'(sum_out), 32'(e.sum));
                check_val("carry", 32'(carry_out), 32'(e.cout));
`ifdef SERIAL_ADDER_OVERFLOW_EN
                check_val("overflow", 32'(overflow_out), 32'(e.ovf));
`endif
            end
        end
    endtask

    task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        int d0;
        int k;
        k = 0;
        while (ready_out !== 1'b1 && k < 20) begin
            step();
            k++;
        end
        check_val("ready_wait", 32'(ready_out), 32'd1);
        d0 = n_done;
        a = x; b = y; cin = c; start = 1'b1;
        step();
        start = 1'b0;
        a = ~x; b = ~y; cin = ~c;
        k = 0;
        while (n_done == d0 && k < 20) begin
            step();
            k++;
        end
        check_val("done_seen", 32'(n_done - d0), 32'd1);
    endtask

    initial begin
        int acc0;
        int d0;
        logic [W-1:0] prev_sum;
        reset_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;

        // Reset state
        step(); step();
        check_val("rst_sum", 32'(sum_out), 32'h0);
        check_val("rst_carry", 32'(carry_out), 32'h0);
        check_val("rst_done", 32'(done_out), 32'h0);
        check_val("rst_ready", 32'(ready_out), 32'h1);
        reset_n = 1'b1;
        step();
        check_val("post_rst_ready", 32'(ready_out), 32'h1);
        check_val("post_rst_done", 32'(done_out), 32'h0);

        // Latency and handshake timing for 0x1234 + 0x4321
        prev_sum = sum_out;
        a = 16'h1234; b = 16'h4321; cin = 1'b0; start = 1'b1;
        step();
        start = 1'b0; a = 16'hDEAD; b = 16'hBEEF; cin = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            check_val($sformatf("lat_ready_c%0d", k), 32'(ready_out), 32'h0);
            check_val($sformatf("lat_done_c%0d", k), 32'(done_out), (k == 5) ? 32'h1 : 32'h0);
            if (k < 5) begin
                check_val($sformatf("sum_hold_c%0d", k), 32'(sum_out), 32'(prev_sum));
                step();
            end
        end
        check_val("lat_sum_5555", 32'(sum_out), 32'h5555);
        step();
        check_val("lat_ready_c6", 32'(ready_out), 32'h1);
        check_val("lat_done_c6", 32'(done_out), 32'h0);

        // Full carry ripple across all nibbles
        run_op(16'hFFFF, 16'h0000, 1'b1);
        check_val("ripple_sum", 32'(sum_out), 32'h0);
        check_val("ripple_carry", 32'(carry_out), 32'h1);

        // start held high through RUN/DONE: second op only on first ready edge
        acc0 = n_acc; d0 = n_done;
        a = 16'h00FF; b = 16'h0001; cin = 1'b0; start = 1'b1;
        step();
        a = 16'hAAAA; b = 16'h5555;
        for (int k = 0; k < 20 && n_acc < acc0 + 2; k++) step();
        start = 1'b0;
        check_val("held_acc_count", 32'(n_acc - acc0), 32'd2);
        check_val("held_acc_spacing", 32'(last_acc_cyc - prev_acc_cyc), 32'd6);
        for (int k = 0; k < 20 && n_done < d0 + 2; k++) step();
        check_val("held_done_count", 32'(n_done - d0), 32'd2);
        check_val("held_sum_ffff", 32'(sum_out), 32'hFFFF);

        // Reset mid-RUN aborts the operation
        step();
        a = 16'h1111; b = 16'h2222; cin = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        step();
        reset_n = 1'b0;
        step();
        check_val("abort_ready", 32'(ready_out), 32'h1);
        check_val("abort_sum", 32'(sum_out), 32'h0);
        check_val("abort_done", 32'(done_out), 32'h0);
        reset_n = 1'b1;
        d0 = n_done;
        for (int k = 0; k < 10; k++) step();
        check_val("abort_no_done", 32'(n_done - d0), 32'd0);

`ifdef SERIAL_ADDER_OVERFLOW_EN
        run_op(16'h7FFF, 16'h0001, 1'b0);
        check_val("ovf_pos", 32'(overflow_out), 32'h1);
        run_op(16'hFFFF, 16'h0001, 1'b0);
        check_val("ovf_wrap", 32'(overflow_out), 32'h0);
`endif

        // Random operands
        for (int k = 0; k < 10; k++) begin
            run_op(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)));
        end
        step(); step();
        check_val("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
